// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, three-cycle branch flush FSM, EX operand forwarding.
// Optional performance counters (StallCnt/FlushCnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  RsAddr_id,
   input  logic [4:0]  RtAddr_id,
   input  logic        Branch_id,
   input  logic        MemRead_ex,
   input  logic        RegWrite_ex,
   input  logic [4:0]  RegWriteAddr_ex,
   input  logic [4:0]  RsAddr_ex,
   input  logic [4:0]  RtAddr_ex,
   input  logic        RegWrite_mem,
   input  logic [4:0]  RegWriteAddr_mem,
   input  logic        BranchTaken_mem,
   input  logic        RegWrite_wb,
   input  logic [4:0]  RegWriteAddr_wb,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFID_Flush,
   output logic        IDEX_Flush,
   output logic [1:0]  ForwardA_ex,
   output logic [1:0]  ForwardB_ex
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BR_EX  = 2'b01,
      BR_MEM = 2'b10
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_load_use;
   logic   w_unused;

   // Load-use detection keys on MemRead alone; the EX write enable plays no part.
   assign w_unused   = RegWrite_ex;
   assign w_load_use = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                       ((RegWriteAddr_ex == RsAddr_id) || (RegWriteAddr_ex == RtAddr_id));

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = IDLE;
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      if (reset) begin
         case (r_state)
            BR_EX: begin
               PCWrite    = 1'b0;
               IFID_Flush = 1'b1;
               w_next     = BR_MEM;
            end
            BR_MEM: begin
               IFID_Flush = BranchTaken_mem;
               w_next     = IDLE;
            end
            default: begin
               // Load-use wins over a coincident branch; the branch re-presents after the stall.
               if (w_load_use) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEX_Flush = 1'b1;
               end else if (Branch_id) begin
                  PCWrite    = 1'b0;
                  IFID_Flush = 1'b1;
                  w_next     = BR_EX;
               end
            end
         endcase
      end
   end

   function automatic logic [1:0] fwd_sel(input logic       rw_mem,
                                          input logic [4:0] wa_mem,
                                          input logic       rw_wb,
                                          input logic [4:0] wa_wb,
                                          input logic [4:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (rw_mem && (wa_mem != 5'd0) && (wa_mem == src))   sel = 2'b10;
      else if (rw_wb && (wa_wb != 5'd0) && (wa_wb == src)) sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ForwardA_ex = '0;
      ForwardB_ex = '0;
      if (reset) begin
         ForwardA_ex = fwd_sel(RegWrite_mem, RegWriteAddr_mem, RegWrite_wb, RegWriteAddr_wb, RsAddr_ex);
         ForwardB_ex = fwd_sel(RegWrite_mem, RegWriteAddr_mem, RegWrite_wb, RegWriteAddr_wb, RtAddr_ex);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // IDEX_Flush is asserted only for a load-use stall, so it doubles as the stall event.
   always_ff @(posedge clk) begin
      if (!reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (IDEX_Flush && (StallCnt != '1)) StallCnt <= StallCnt + 32'd1;
         if (IFID_Flush && (FlushCnt != '1)) FlushCnt <= FlushCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard/branch/reset sequences plus randomized forwarding.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs_id;
      logic [4:0] rt_id;
      logic       br_id;
      logic       mr_ex;
      logic       rw_ex;
      logic [4:0] wa_ex;
      logic [4:0] rs_ex;
      logic [4:0] rt_ex;
      logic       rw_mem;
      logic [4:0] wa_mem;
      logic       bt;
      logic       rw_wb;
      logic [4:0] wa_wb;
   } stim_t;

   // {PCWrite, IFIDWrite, IFID_Flush, IDEX_Flush, ForwardA_ex, ForwardB_ex}
   localparam logic [7:0] E_RUN   = 8'b1100_0000;
   localparam logic [7:0] E_STALL = 8'b0001_0000;
   localparam logic [7:0] E_BR    = 8'b0110_0000;
   localparam logic [7:0] E_BRT   = 8'b1110_0000;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RsAddr_id, RtAddr_id, RegWriteAddr_ex, RsAddr_ex, RtAddr_ex;
   logic [4:0] RegWriteAddr_mem, RegWriteAddr_wb;
   logic       Branch_id, MemRead_ex, RegWrite_ex, RegWrite_mem, BranchTaken_mem, RegWrite_wb;
   logic       PCWrite, IFIDWrite, IFID_Flush, IDEX_Flush;
   logic [1:0] ForwardA_ex, ForwardB_ex;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] StallCnt, FlushCnt;
`endif

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   logic [7:0]  sb_q[$];

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .RsAddr_id        (RsAddr_id),
      .RtAddr_id        (RtAddr_id),
      .Branch_id        (Branch_id),
      .MemRead_ex       (MemRead_ex),
      .RegWrite_ex      (RegWrite_ex),
      .RegWriteAddr_ex  (RegWriteAddr_ex),
      .RsAddr_ex        (RsAddr_ex),
      .RtAddr_ex        (RtAddr_ex),
      .RegWrite_mem     (RegWrite_mem),
      .RegWriteAddr_mem (RegWriteAddr_mem),
      .BranchTaken_mem  (BranchTaken_mem),
      .RegWrite_wb      (RegWrite_wb),
      .RegWriteAddr_wb  (RegWriteAddr_wb),
      .PCWrite          (PCWrite),
      .IFIDWrite        (IFIDWrite),
      .IFID_Flush       (IFID_Flush),
      .IDEX_Flush       (IDEX_Flush),
      .ForwardA_ex      (ForwardA_ex),
      .ForwardB_ex      (ForwardB_ex)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .StallCnt         (StallCnt),
      .FlushCnt         (FlushCnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s     = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   function automatic logic [1:0] fwd_model(input logic rw_mem, input logic [4:0] wa_mem,
                                            input logic rw_wb, input logic [4:0] wa_wb,
                                            input logic [4:0] src);
      if (rw_mem && wa_mem != 5'd0 && wa_mem == src) return 2'b10;
      if (rw_wb && wa_wb != 5'd0 && wa_wb == src)    return 2'b01;
      return 2'b00;
   endfunction

   // Drives one cycle of inputs just after a rising edge, checks outputs at the falling edge.
   task automatic step(input stim_t s, input logic [7:0] e, input string tag);
      logic [7:0] exp_v;
      logic [7:0] got_v;
      reset            = s.rst;
      RsAddr_id        = s.rs_id;
      RtAddr_id        = s.rt_id;
      Branch_id        = s.br_id;
      MemRead_ex       = s.mr_ex;
      RegWrite_ex      = s.rw_ex;
      RegWriteAddr_ex  = s.wa_ex;
      RsAddr_ex        = s.rs_ex;
      RtAddr_ex        = s.rt_ex;
      RegWrite_mem     = s.rw_mem;
      RegWriteAddr_mem = s.wa_mem;
      BranchTaken_mem  = s.bt;
      RegWrite_wb      = s.rw_wb;
      RegWriteAddr_wb  = s.wa_wb;
      sb_q.push_back(e);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      got_v = {PCWrite, IFIDWrite, IFID_Flush, IDEX_Flush, ForwardA_ex, ForwardB_ex};
      chk(tag, 32'(got_v), 32'(exp_v));
      @(posedge clk);
      #1;
   endtask

   initial begin
      stim_t s;
      logic [1:0] fa, fb;
      @(posedge clk);
      #1;

      // Reset with every hazard condition active: outputs must stay at their defaults.
      s = idle_s(); s.rst = 1'b0; s.mr_ex = 1'b1; s.wa_ex = 5'd2; s.rs_id = 5'd2; s.br_id = 1'b1;
      s.rw_mem = 1'b1; s.wa_mem = 5'd3; s.rs_ex = 5'd3; s.rt_ex = 5'd3;
      step(s, E_RUN, "reset_out0");
      step(s, E_RUN, "reset_out1");

      step(idle_s(), E_RUN, "idle");

      // lw $2 in EX, add $3,$2,$4 in ID
      s = idle_s(); s.mr_ex = 1'b1; s.rw_ex = 1'b1; s.wa_ex = 5'd2; s.rs_id = 5'd2; s.rt_id = 5'd4;
      step(s, E_STALL, "lu_rs");
      s = idle_s(); s.rw_mem = 1'b1; s.wa_mem = 5'd2; s.rs_id = 5'd2; s.rt_id = 5'd4;
      step(s, E_RUN, "lu_after");
      s = idle_s(); s.mr_ex = 1'b1; s.rw_ex = 1'b1; s.wa_ex = 5'd7; s.rs_id = 5'd1; s.rt_id = 5'd7;
      step(s, E_STALL, "lu_rt");
      s = idle_s(); s.mr_ex = 1'b1; s.wa_ex = 5'd0; s.rs_id = 5'd0; s.rt_id = 5'd0;
      step(s, E_RUN, "lu_r0");
      s = idle_s(); s.rw_ex = 1'b1; s.wa_ex = 5'd6; s.rs_id = 5'd6;
      step(s, E_RUN, "no_load");

      // Load-use and branch together, then a taken branch with ignored inputs in BR_EX/BR_MEM.
      s = idle_s(); s.mr_ex = 1'b1; s.wa_ex = 5'd8; s.rs_id = 5'd8; s.br_id = 1'b1;
      step(s, E_STALL, "lu_br");
      s = idle_s(); s.br_id = 1'b1;
      step(s, E_BR, "br_id");
      s = idle_s(); s.br_id = 1'b1; s.mr_ex = 1'b1; s.wa_ex = 5'd9; s.rs_id = 5'd9; s.bt = 1'b1;
      step(s, E_BR, "br_ex");
      step(s, E_BRT, "br_mem_taken");
      s = idle_s(); s.bt = 1'b1;
      step(s, E_RUN, "br_done");

      // Not-taken branch.
      s = idle_s(); s.br_id = 1'b1;
      step(s, E_BR, "nt_id");
      step(idle_s(), E_BR, "nt_ex");
      step(idle_s(), E_RUN, "nt_mem");
      s = idle_s(); s.br_id = 1'b1;
      step(s, E_BR, "nt_again");
      step(idle_s(), E_BR, "nt_again_ex");
      s = idle_s(); s.bt = 1'b1;
      step(s, E_BRT, "t_mem");

      // Reset asserted during BR_EX: no BR_MEM cycle follows.
      s = idle_s(); s.br_id = 1'b1;
      step(s, E_BR, "rst_br_id");
      s = idle_s(); s.rst = 1'b0; s.bt = 1'b1;
      step(s, E_RUN, "rst_in_brex");
      s = idle_s(); s.bt = 1'b1;
      step(s, E_RUN, "rst_no_brmem");

      // Forwarding.
      s = idle_s(); s.rw_mem = 1'b1; s.wa_mem = 5'd5; s.rw_wb = 1'b1; s.wa_wb = 5'd5;
      s.rs_ex = 5'd5; s.rt_ex = 5'd0;
      step(s, E_RUN | 8'b0000_1000, "fwd_mem_prio");
      s = idle_s(); s.rw_mem = 1'b1; s.wa_mem = 5'd0; s.rs_ex = 5'd0;
      step(s, E_RUN, "fwd_r0");
      s = idle_s(); s.rw_wb = 1'b1; s.wa_wb = 5'd9; s.rt_ex = 5'd9;
      step(s, E_RUN | 8'b0000_0001, "fwd_wb_b");
      s = idle_s(); s.rw_mem = 1'b0; s.wa_mem = 5'd5; s.rw_wb = 1'b1; s.wa_wb = 5'd5; s.rs_ex = 5'd5;
      step(s, E_RUN | 8'b0000_0100, "fwd_wb_a");
      for (int i = 0; i < 32; i++) begin
         s = idle_s();
         s.rw_mem = 1'($urandom_range(0, 1));
         s.wa_mem = 5'($urandom_range(0, 3));
         s.rw_wb  = 1'($urandom_range(0, 1));
         s.wa_wb  = 5'($urandom_range(0, 3));
         s.rs_ex  = 5'($urandom_range(0, 3));
         s.rt_ex  = 5'($urandom_range(0, 3));
         fa = fwd_model(s.rw_mem, s.wa_mem, s.rw_wb, s.wa_wb, s.rs_ex);
         fb = fwd_model(s.rw_mem, s.wa_mem, s.rw_wb, s.wa_wb, s.rt_ex);
         step(s, E_RUN | {4'b0000, fa, fb}, "fwd_rand");
      end

`ifdef HAZARD_PERF_CNT_EN
      s = idle_s(); s.rst = 1'b0;
      step(s, E_RUN, "cnt_reset");
      chk("stallcnt_rst", StallCnt, 32'd0);
      chk("flushcnt_rst", FlushCnt, 32'd0);
      s = idle_s(); s.mr_ex = 1'b1; s.wa_ex = 5'd4; s.rs_id = 5'd4;
      step(s, E_STALL, "cnt_lu0");
      step(idle_s(), E_RUN, "cnt_gap");
      step(s, E_STALL, "cnt_lu1");
      s = idle_s(); s.br_id = 1'b1;
      step(s, E_BR, "cnt_br");
      step(idle_s(), E_BR, "cnt_brex");
      s = idle_s(); s.bt = 1'b1;
      step(s, E_BRT, "cnt_brmem");
      step(idle_s(), E_RUN, "cnt_idle");
      chk("stallcnt", StallCnt, 32'd2);
      chk("flushcnt", FlushCnt, 32'd3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
